// File: rtl/madd_err_accum.sv
// madd_err_accum: error accumulator for an approximate multiply-add unit.
//
// Each accepted sample carries operands a, b, c and the result "approx"
// produced by the unit under test. The block computes the exact result
// a*b + c, takes |approx - exact| and accumulates statistics over a run
// of N_SAMPLES samples.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse: clear statistics and begin a run
//   in_valid / in_ready   sample handshake (accepted when both are high)
//   op_a, op_b, op_c      multiply-add operands
//   approx                approximate result under test
//   busy                  run in progress (RUN or DRAIN)
//   done                  run complete, held until the next start
//   smp_cnt               samples accumulated
//   err_cnt               samples whose approx differs from exact
//   sum_abs               sum of absolute errors
//   max_abs               largest absolute error seen
//   max_a, max_b, max_c   operands of the first sample that reached max_abs
module madd_err_accum #(
  parameter int N_SAMPLES = 262144,
  parameter int OPW       = 6,
  parameter int RW        = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    op_a,
  input  logic [OPW-1:0]    op_b,
  input  logic [OPW-1:0]    op_c,
  input  logic [RW-1:0]     approx,
  output logic              busy,
  output logic              done,
  output logic [18:0]       smp_cnt,
  output logic [18:0]       err_cnt,
  output logic [31:0]       sum_abs,
  output logic [RW-1:0]     max_abs,
  output logic [OPW-1:0]    max_a,
  output logic [OPW-1:0]    max_b,
  output logic [OPW-1:0]    max_c
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [18:0] LAST_IDX = 19'(N_SAMPLES - 1);

  // Absolute value of a signed difference, returned at result width.
  // The difference of two RW-bit unsigned values never reaches -2^RW,
  // so the magnitude always fits in RW bits.
  function automatic logic [RW-1:0] abs_err(input logic signed [RW:0] d);
    logic [RW:0] m;
    m = d[RW] ? RW'(0) - d : d;
    return m[RW-1:0];
  endfunction

  logic [1:0]           r_rst_sync;
  logic [1:0]           r_state;
  logic [18:0]          r_acc_cnt;
  logic                 r_vld_p0;
  logic                 r_vld_p1;

  logic [OPW-1:0]       r_a_p0, r_b_p0, r_c_p0;
  logic [RW-1:0]        r_approx_p0;
  logic [OPW-1:0]       r_a_p1, r_b_p1, r_c_p1;
  logic [RW-1:0]        r_abs_p1;

  logic [18:0]          r_smp;
  logic [18:0]          r_err;
  logic [31:0]          r_sum;
  logic [RW-1:0]        r_max;
  logic [OPW-1:0]       r_max_a, r_max_b, r_max_c;

  logic                 w_run_en;
  logic                 w_start;
  logic                 w_accept;
  logic                 w_last;
  logic [RW-1:0]        w_exact_p0;
  logic signed [RW:0]   w_diff_p0;

  // Reset release is re-timed through two flops; start is ignored until
  // the block has seen two clean edges after deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run_en = r_rst_sync[1];
  assign w_start  = start & w_run_en;

  // A start cycle never accepts a sample, even while in RUN.
  assign in_ready = (r_state == S_RUN) & ~start;
  assign w_accept = in_valid & in_ready;
  assign w_last   = w_accept & (r_acc_cnt == LAST_IDX);

  assign busy = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);

  // Control: FSM, accept counter, valid pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc_cnt <= '0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else if (w_start) begin
      r_state   <= S_RUN;
      r_acc_cnt <= '0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept;
      r_vld_p1 <= r_vld_p0;
      if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + 19'd1;
      end
      case (r_state)
        S_RUN:   if (w_last) r_state <= S_DRAIN;
        S_DRAIN: if (!r_vld_p0 && !r_vld_p1) r_state <= S_DONE;
        default: r_state <= r_state;
      endcase
    end
  end

  // Stage 1 -> 2: exact result and absolute error from registered operands
  assign w_exact_p0 = RW'(r_a_p0) * RW'(r_b_p0) + RW'(r_c_p0);
  assign w_diff_p0  = $signed({1'b0, r_approx_p0}) - $signed({1'b0, w_exact_p0});

  // Stage 0 and stage 1 data registers (qualified by r_vld_p0 / r_vld_p1)
  always_ff @(posedge clk) begin
    r_a_p0      <= op_a;
    r_b_p0      <= op_b;
    r_c_p0      <= op_c;
    r_approx_p0 <= approx;
    r_a_p1      <= r_a_p0;
    r_b_p1      <= r_b_p0;
    r_c_p1      <= r_c_p0;
    r_abs_p1    <= abs_err(w_diff_p0);
  end

  // Stage 2: accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp   <= '0;
      r_err   <= '0;
      r_sum   <= '0;
      r_max   <= '0;
      r_max_a <= '0;
      r_max_b <= '0;
      r_max_c <= '0;
    end else if (w_start) begin
      r_smp   <= '0;
      r_err   <= '0;
      r_sum   <= '0;
      r_max   <= '0;
      r_max_a <= '0;
      r_max_b <= '0;
      r_max_c <= '0;
    end else if (r_vld_p1) begin
      r_smp <= r_smp + 19'd1;
      if (r_abs_p1 != '0) begin
        r_err <= r_err + 19'd1;
      end
      r_sum <= r_sum + 32'(r_abs_p1);
      // Strictly greater keeps the operands of the first occurrence.
      if (r_abs_p1 > r_max) begin
        r_max   <= r_abs_p1;
        r_max_a <= r_a_p1;
        r_max_b <= r_b_p1;
        r_max_c <= r_c_p1;
      end
    end
  end

  assign smp_cnt = r_smp;
  assign err_cnt = r_err;
  assign sum_abs = r_sum;
  assign max_abs = r_max;
  assign max_a   = r_max_a;
  assign max_b   = r_max_b;
  assign max_c   = r_max_c;

endmodule

// File: tb/tb_madd_err_accum.sv
// Testbench for madd_err_accum. Three instances with different run lengths
// share one stimulus stream; "sel" picks the instance a test observes.
// Expected statistics come from a queue of accepted samples folded with
// plain integer arithmetic.
module tb_madd_err_accum;

  localparam int NI = 3;
  localparam int NL = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  op_a = '0, op_b = '0, op_c = '0;
  logic [11:0] approx = '0;

  logic        rdy [NI];
  logic        bsy [NI];
  logic        dn  [NI];
  logic [18:0] smp [NI];
  logic [18:0] errc[NI];
  logic [31:0] sab [NI];
  logic [11:0] mab [NI];
  logic [5:0]  ma  [NI];
  logic [5:0]  mb  [NI];
  logic [5:0]  mc  [NI];

  always #5 clk = ~clk;

  madd_err_accum #(.N_SAMPLES(2), .OPW(6), .RW(12)) u_n2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy[0]),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .approx(approx), .busy(bsy[0]), .done(dn[0]),
    .smp_cnt(smp[0]), .err_cnt(errc[0]), .sum_abs(sab[0]), .max_abs(mab[0]),
    .max_a(ma[0]), .max_b(mb[0]), .max_c(mc[0]));

  madd_err_accum #(.N_SAMPLES(4), .OPW(6), .RW(12)) u_n4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy[1]),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .approx(approx), .busy(bsy[1]), .done(dn[1]),
    .smp_cnt(smp[1]), .err_cnt(errc[1]), .sum_abs(sab[1]), .max_abs(mab[1]),
    .max_a(ma[1]), .max_b(mb[1]), .max_c(mc[1]));

  madd_err_accum #(.N_SAMPLES(NL), .OPW(6), .RW(12)) u_nl (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy[2]),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .approx(approx), .busy(bsy[2]), .done(dn[2]),
    .smp_cnt(smp[2]), .err_cnt(errc[2]), .sum_abs(sab[2]), .max_abs(mab[2]),
    .max_a(ma[2]), .max_b(mb[2]), .max_c(mc[2]));

  int n_vec = 0;
  int n_err = 0;
  int sel = 0;

  int q_a[$];
  int q_b[$];
  int q_c[$];
  int q_x[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_model();
    q_a.delete();
    q_b.delete();
    q_c.delete();
    q_x.delete();
  endtask

  // Offer one sample for one clock; record it if the observed instance took it.
  task automatic send(input int a, input int b, input int c, input int x);
    op_a     = 6'(a);
    op_b     = 6'(b);
    op_c     = 6'(c);
    approx   = 12'(x);
    in_valid = 1'b1;
    start    = 1'b0;
    @(negedge clk);
    if (rdy[sel]) begin
      q_a.push_back(a);
      q_b.push_back(b);
      q_c.push_back(c);
      q_x.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Start pulse with a sample offered in the same cycle; it must be dropped.
  task automatic do_start();
    op_a     = 6'($urandom_range(0, 63));
    op_b     = 6'($urandom_range(0, 63));
    op_c     = 6'($urandom_range(0, 63));
    approx   = 12'($urandom_range(0, 4095));
    start    = 1'b1;
    in_valid = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    clear_model();
  endtask

  // Random sample; approx is exact, near exact, random, or an extreme value.
  task automatic gen(input bit exact_only, output int a, output int b, output int c, output int x);
    int ex;
    int mode;
    a  = int'($urandom_range(0, 63));
    b  = int'($urandom_range(0, 63));
    c  = int'($urandom_range(0, 63));
    ex = a * b + c;
    mode = exact_only ? 0 : int'($urandom_range(0, 3));
    case (mode)
      0: x = ex;
      1: begin
        x = ex + int'($urandom_range(0, 16)) - 8;
        if (x < 0) x = 0;
        if (x > 4095) x = 4095;
      end
      2: x = int'($urandom_range(0, 4095));
      default: x = ($urandom_range(0, 1) == 1) ? 4095 : 0;
    endcase
  endtask

  // Fold the accepted samples into the statistics the run should report.
  task automatic exp_check(input string tag);
    int e_smp, e_err, e_sum, e_max, e_a, e_b, e_c, d;
    e_smp = 0; e_err = 0; e_sum = 0; e_max = 0; e_a = 0; e_b = 0; e_c = 0;
    foreach (q_a[i]) begin
      d = q_x[i] - (q_a[i] * q_b[i] + q_c[i]);
      if (d < 0) d = -d;
      e_smp++;
      if (d != 0) e_err++;
      e_sum += d;
      if (d > e_max) begin
        e_max = d;
        e_a = q_a[i];
        e_b = q_b[i];
        e_c = q_c[i];
      end
    end
    chk({tag, ".smp"}, 32'(smp[sel]), 32'(e_smp));
    chk({tag, ".err"}, 32'(errc[sel]), 32'(e_err));
    chk({tag, ".sum"}, sab[sel], 32'(e_sum));
    chk({tag, ".max"}, 32'(mab[sel]), 32'(e_max));
    chk({tag, ".max_a"}, 32'(ma[sel]), 32'(e_a));
    chk({tag, ".max_b"}, 32'(mb[sel]), 32'(e_b));
    chk({tag, ".max_c"}, 32'(mc[sel]), 32'(e_c));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".smp"}, 32'(smp[sel]), 32'd0);
    chk({tag, ".err"}, 32'(errc[sel]), 32'd0);
    chk({tag, ".sum"}, sab[sel], 32'd0);
    chk({tag, ".max"}, 32'(mab[sel]), 32'd0);
    chk({tag, ".max_abc"}, 32'({ma[sel], mb[sel], mc[sel]}), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && !dn[sel]; i++) tick();
    chk({tag, ".done"}, 32'(dn[sel]), 32'd1);
  endtask

  initial begin
    int a, b, c, x, guard;

    // Reset state of every instance
    rst_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      sel = i;
      chk("rst.busy", 32'(bsy[i]), 32'd0);
      chk("rst.done", 32'(dn[i]), 32'd0);
      chk("rst.rdy", 32'(rdy[i]), 32'd0);
      chk_cleared("rst");
    end
    rst_n = 1'b1;
    tick();
    chk("rel.busy", 32'(bsy[0]), 32'd0);
    chk("rel.rdy", 32'(rdy[0]), 32'd0);
    idle(3);

    // Samples offered in IDLE are ignored
    sel = 0;
    send(5, 5, 5, 0);
    idle(4);
    chk("idle.smp", 32'(smp[0]), 32'd0);
    chk("idle.q", 32'(q_a.size()), 32'd0);

    // Four exact samples, pipeline latency and drain timing
    sel = 1;
    do_start();
    chk("t1.busy", 32'(bsy[1]), 32'd1);
    gen(1'b1, a, b, c, x); send(a, b, c, x);
    gen(1'b1, a, b, c, x); send(a, b, c, x);
    chk("t1.lat0", 32'(smp[1]), 32'd0);
    gen(1'b1, a, b, c, x); send(a, b, c, x);
    chk("t1.lat1", 32'(smp[1]), 32'd1);
    gen(1'b1, a, b, c, x); send(a, b, c, x);
    chk("t1.lat2", 32'(smp[1]), 32'd2);
    chk("t1.drain_rdy", 32'(rdy[1]), 32'd0);
    chk("t1.drain_busy", 32'(bsy[1]), 32'd1);
    tick();
    chk("t1.done_e1", 32'(dn[1]), 32'd0);
    tick();
    chk("t1.done_e2", 32'(dn[1]), 32'd0);
    chk("t1.smp_e2", 32'(smp[1]), 32'd4);
    tick();
    chk("t1.done_e3", 32'(dn[1]), 32'd1);
    chk("t1.busy_e3", 32'(bsy[1]), 32'd0);
    exp_check("t1");

    // Worst-case error followed by a small one
    sel = 0;
    do_start();
    send(63, 63, 63, 0);
    send(1, 1, 0, 3);
    wait_done("t2", 8);
    chk("t2.err", 32'(errc[0]), 32'd2);
    chk("t2.sum", sab[0], 32'd4034);
    chk("t2.max", 32'(mab[0]), 32'd4032);
    chk("t2.abc", 32'({ma[0], mb[0], mc[0]}), 32'({6'd63, 6'd63, 6'd63}));
    exp_check("t2");
    // Samples offered in DONE are ignored
    send(7, 7, 7, 0);
    idle(4);
    chk("t2.done_ignore", 32'(smp[0]), 32'd2);
    chk("t2.done_hold", 32'(dn[0]), 32'd1);

    // Tie on the maximum keeps the first sample's operands
    do_start();
    chk_cleared("t3.clr");
    send(2, 3, 0, 11);
    send(1, 1, 1, 7);
    wait_done("t3", 8);
    chk("t3.max", 32'(mab[0]), 32'd5);
    chk("t3.abc", 32'({ma[0], mb[0], mc[0]}), 32'({6'd2, 6'd3, 6'd0}));
    exp_check("t3");

    // Continuous stream of exact samples, no stall, done 3 edges after last accept
    sel = 2;
    do_start();
    for (int i = 0; i < NL; i++) begin
      gen(1'b1, a, b, c, x);
      send(a, b, c, x);
    end
    chk("t4.accepted", 32'(q_a.size()), 32'(NL));
    tick();
    chk("t4.done_e1", 32'(dn[2]), 32'd0);
    tick();
    chk("t4.done_e2", 32'(dn[2]), 32'd0);
    tick();
    chk("t4.done_e3", 32'(dn[2]), 32'd1);
    exp_check("t4");

    // Random runs with gaps on the short instance
    sel = 1;
    for (int r = 0; r < 8; r++) begin
      do_start();
      guard = 0;
      while (q_a.size() < 4 && guard < 50) begin
        idle(int'($urandom_range(0, 2)));
        gen(1'b0, a, b, c, x);
        send(a, b, c, x);
        guard++;
      end
      wait_done("rnd4", 10);
      exp_check("rnd4");
    end

    // Random run with gaps on the long instance, including long stalls
    sel = 2;
    do_start();
    guard = 0;
    while (q_a.size() < 100 && guard < 400) begin
      idle(int'($urandom_range(0, 1)));
      gen(1'b0, a, b, c, x);
      send(a, b, c, x);
      guard++;
    end
    idle(3);
    exp_check("stall1");
    idle(20);
    exp_check("stall2");
    guard = 0;
    while (q_a.size() < NL && guard < 2000) begin
      idle(int'($urandom_range(0, 2)));
      gen(1'b0, a, b, c, x);
      send(a, b, c, x);
      guard++;
    end
    wait_done("rndl", 10);
    exp_check("rndl");

    // Restart while two samples are still in the pipeline
    do_start();
    for (int i = 0; i < 7; i++) begin
      gen(1'b0, a, b, c, x);
      send(a, b, c, x);
    end
    chk("t8.pre", 32'(smp[2]), 32'(q_a.size() - 2));
    do_start();
    chk_cleared("t8.clr");
    chk("t8.busy", 32'(bsy[2]), 32'd1);
    idle(3);
    chk("t8.flushed", 32'(smp[2]), 32'd0);
    gen(1'b0, a, b, c, x); send(a, b, c, x);
    gen(1'b0, a, b, c, x); send(a, b, c, x);
    idle(3);
    exp_check("t8");
    chk("t8.smp2", 32'(smp[2]), 32'd2);

    // Asynchronous reset in the middle of a run
    do_start();
    for (int i = 0; i < 10; i++) begin
      gen(1'b0, a, b, c, x);
      send(a, b, c, x);
    end
    rst_n = 1'b0;
    #2;
    chk_cleared("t7.async");
    chk("t7.busy", 32'(bsy[2]), 32'd0);
    chk("t7.rdy", 32'(rdy[2]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7.idle", 32'(bsy[2]), 32'd0);
    chk("t7.smp0", 32'(smp[2]), 32'd0);
    idle(3);
    do_start();
    gen(1'b0, a, b, c, x); send(a, b, c, x);
    gen(1'b0, a, b, c, x); send(a, b, c, x);
    idle(3);
    exp_check("t7");
    chk("t7.smp2", 32'(smp[2]), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
